// File: rtl/pwm_multi_ch.sv
// ---------------------------------------------------------------------------
// PwmMultiCh -- multi-channel PWM generator sharing one prescaled timebase.
//
// Every channel has a shadow duty register, written at any time through a
// one-clk strobe, and an active duty register that only changes at the
// period wrap. Duty and frequency changes therefore never land mid-period.
//
// Optional feature macro: PWM_MULTI_CH_CENTER_ALIGN_EN
//   undefined : edge-aligned counting 0..STEPS-1, 0, ...
//   defined   : center-aligned counting 0..STEPS-1, STEPS-2..1, 0, ...
//
// Parameters
//   CH    number of PWM channels
//   STEPS duty resolution in steps per edge-aligned period (2..4096)
//   PSW   prescaler width
//   DW    derived per-channel duty width, clog2(STEPS+1)
//
// Ports
//   clk          system clock, all logic on posedge
//   rstn         asynchronous active-low reset
//   en           timebase run enable
//   prescale     clocks per step minus 1, taken at each wrap
//   duty_in      packed duty words, channel i at [i*DW +: DW]
//   duty_wr      per-channel write strobes
//   pwm_out      registered PWM outputs
//   duty_pending shadow written but not yet active
//   period_tick  one-clk pulse in the clk after each period wrap
// ---------------------------------------------------------------------------
module pwm_multi_ch #(
    parameter int CH    = 4,
    parameter int STEPS = 100,
    parameter int PSW   = 16,
    localparam int DW   = $clog2(STEPS + 1)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              en,
    input  logic [PSW-1:0]    prescale,
    input  logic [CH*DW-1:0]  duty_in,
    input  logic [CH-1:0]     duty_wr,
    output logic [CH-1:0]     pwm_out,
    output logic [CH-1:0]     duty_pending,
    output logic              period_tick
);

    localparam logic [DW-1:0] LAST_CNT = DW'(STEPS - 1);

    logic [PSW-1:0]         r_presc;
    logic [PSW-1:0]         r_prescAct;
    logic [DW-1:0]          r_cnt;
    logic [CH-1:0][DW-1:0]  r_shadow;
    logic [CH-1:0][DW-1:0]  r_active;
    logic [CH-1:0]          r_pwm;
    logic [CH-1:0]          r_pending;
    logic                   r_tick;

    logic                   w_step;
    logic                   w_wrap;
    logic [DW-1:0]          w_cntNext;

    // One step pulse per (prescale_act + 1) clks. The >= only matters as a
    // safety net; the prescaler is always reset whenever prescale_act moves.
    assign w_step = en && (r_presc >= r_prescAct);

`ifdef PWM_MULTI_CH_CENTER_ALIGN_EN
    logic r_down;
    logic w_downNext;

    // Up/down step counter. The period ends on the step from 1 into 0, so the
    // top value STEPS-1 is visited once and 0 is visited once per period.
    // With STEPS=2 there is no down leg: the step from 1 straight to 0 wraps.
    always_comb begin
        w_cntNext  = r_cnt;
        w_downNext = r_down;
        w_wrap     = 1'b0;
        if (w_step) begin
            if (!r_down) begin
                if (r_cnt == LAST_CNT) begin
                    if (STEPS == 2) begin
                        w_cntNext = '0;
                        w_wrap    = 1'b1;
                    end else begin
                        w_cntNext  = r_cnt - DW'(1);
                        w_downNext = 1'b1;
                    end
                end else begin
                    w_cntNext = r_cnt + DW'(1);
                end
            end else begin
                w_cntNext = r_cnt - DW'(1);
                if (r_cnt == DW'(1)) begin
                    w_downNext = 1'b0;
                    w_wrap     = 1'b1;
                end
            end
        end
    end

    // Direction restarts upwards whenever the timebase is stopped.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_down <= 1'b0;
        end else if (!en) begin
            r_down <= 1'b0;
        end else begin
            r_down <= w_downNext;
        end
    end
`else
    // Edge-aligned step counter 0..STEPS-1, wrapping back to 0.
    always_comb begin
        w_cntNext = r_cnt;
        w_wrap    = w_step && (r_cnt == LAST_CNT);
        if (w_step) begin
            w_cntNext = w_wrap ? '0 : r_cnt + DW'(1);
        end
    end
`endif

    // Shared timebase and registered outputs. While stopped everything is
    // parked at 0 and prescale_act follows the input so the first period
    // after enabling already runs at the requested rate.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_presc    <= '0;
            r_prescAct <= '0;
            r_cnt      <= '0;
            r_pwm      <= '0;
            r_tick     <= 1'b0;
        end else if (!en) begin
            r_presc    <= '0;
            r_prescAct <= prescale;
            r_cnt      <= '0;
            r_pwm      <= '0;
            r_tick     <= 1'b0;
        end else begin
            r_presc <= w_step ? '0 : r_presc + PSW'(1);
            r_cnt   <= w_cntNext;
            r_tick  <= w_wrap;
            if (w_wrap) begin
                r_prescAct <= prescale;
            end
            for (int i = 0; i < CH; i++) begin
                r_pwm[i] <= (r_cnt < r_active[i]);
            end
        end
    end

    // Per-channel duty registers. A write landing in the wrap clk (or while
    // stopped) goes straight through to active, so it is never left pending
    // and never lost behind the stale shadow value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_shadow  <= '0;
            r_active  <= '0;
            r_pending <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (duty_wr[i]) begin
                    r_shadow[i] <= duty_in[i*DW +: DW];
                end
                if (!en || w_wrap) begin
                    r_active[i] <= duty_wr[i] ? duty_in[i*DW +: DW] : r_shadow[i];
                end
                if (!en) begin
                    r_pending[i] <= 1'b0;
                end else if (duty_wr[i]) begin
                    r_pending[i] <= !w_wrap;
                end else if (w_wrap) begin
                    r_pending[i] <= 1'b0;
                end
            end
        end
    end

    assign pwm_out      = r_pwm;
    assign duty_pending = r_pending;
    assign period_tick  = r_tick;

endmodule

// File: doc/pwm_multi_ch.md
PWM_MULTI_CH -- requirements
Module: pwm_multi_ch

Interface
REQ-001 The block SHALL have parameter CH, default 4, the number of independent PWM channels sharing one timebase.
REQ-002 The block SHALL have parameter STEPS, default 100, the duty resolution in steps per edge-aligned period. Legal range 2..4096.
REQ-003 The block SHALL have parameter PSW, default 16, the prescaler width.
REQ-004 The block SHALL derive localparam DW = clog2(STEPS+1), the per-channel duty width.
REQ-005 The block SHALL have port clk, input, 1 bit: the single system clock; all logic is on posedge.
REQ-006 The block SHALL have port rstn, input, 1 bit: the reset, which is asynchronous and active-low.
REQ-007 The block SHALL have port en, input, 1 bit: the timebase run enable.
REQ-008 The block SHALL have port prescale, input, PSW bits: clocks per step minus 1.
REQ-009 The block SHALL have port duty_in, input, CH*DW bits: packed duty words, where channel i is bits [i*DW +: DW].
REQ-010 The block SHALL have port duty_wr, input, CH bits: per-channel write strobes, each one clk wide.
REQ-011 The block SHALL have port pwm_out, output, CH bits: the registered PWM outputs.
REQ-012 The block SHALL have port duty_pending, output, CH bits: the channel's shadow value is written but not yet active.
REQ-013 The block SHALL have port period_tick, output, 1 bit: a one-clk pulse at each period wrap.

Function
REQ-014 The block SHALL use a prescaler counter that counts 0..prescale_act and issues a step pulse in the clk where it equals prescale_act, then returns to 0; prescale=0 gives a step every clk.
REQ-015 In edge-aligned mode, the step counter cnt SHALL advance 0,1,..,STEPS-1,0 on each step pulse; the wrap is the step pulse taking cnt from STEPS-1 to 0.
REQ-016 The block SHALL keep a DW-bit shadow and active register per channel; duty_wr[i]=1 SHALL load shadow[i] from duty_in[i] and set duty_pending[i] on the next clk.
REQ-017 At each wrap, active[i] SHALL take shadow[i], prescale_act SHALL take prescale, and all duty_pending bits SHALL clear; duty and frequency changes therefore never take effect mid-period.
REQ-018 If duty_wr[i] and a wrap occur in the same clk, the new value SHALL go to both shadow and active, and duty_pending[i] SHALL stay 0.
REQ-019 Each clk, pwm_out[i] SHALL be set to en AND (cnt < active[i]), giving 1 clk latency from cnt to output.
REQ-020 Duty 0 SHALL give a constant 0 output; duty >= STEPS SHALL give a constant 1 output with no glitch at the wrap.
REQ-021 period_tick SHALL be registered and SHALL assert for 1 clk, in the clk after the wrap step pulse.
REQ-022 While en=0: the prescaler and cnt SHALL be held at 0; pwm_out and period_tick SHALL be 0; active SHALL be set from shadow and prescale_act from prescale every clk; duty_pending SHALL read 0.
REQ-023 On an en 0->1 transition, counting SHALL start at cnt=0, and the first step pulse SHALL come prescale_act+1 clks later.
REQ-024 Writes to channel i SHALL never disturb any other channel; duty_wr may be any bit combination, including all bits set.

Reset
REQ-025 On rstn=0, the block SHALL asynchronously clear the prescaler, cnt, count direction, all shadow and active registers, prescale_act, pwm_out, duty_pending and period_tick to 0.
REQ-026 The block SHALL release reset synchronously to clk; if reset occurs mid-period, operation SHALL restart from cnt=0 with duty 0 on every channel until duty is rewritten.

Configuration
REQ-027 With macro PWM_MULTI_CH_CENTER_ALIGN_EN defined, cnt SHALL count up 0..STEPS-1 and then down STEPS-2..1, for a period of 2*(STEPS-1) steps; the wrap is the step into cnt=0 from 1, and the output rule of REQ-019 SHALL be unchanged, which gives centred pulses.
REQ-028 Without PWM_MULTI_CH_CENTER_ALIGN_EN, the block SHALL be edge-aligned only, and no direction logic SHALL be synthesised.

Verification
REQ-029 The bench SHALL cover: CH=4, STEPS=100, prescale=0, en=1, duty0=25 written once at start -> after the first wrap, pwm_out[0] is high 25 clks and low 75 clks per period, and period_tick pulses every 100 clks.
REQ-030 The bench SHALL cover: duty0=25 active, then duty_wr[0] with 60 while cnt=30 -> duty_pending[0]=1 and the current period keeps 25 high clks; the next period has 60 high clks; pending clears at the wrap.
REQ-031 The bench SHALL cover: duty_in channels 1,2,3 = 0,100,127 written, wrap -> pwm_out[1] constant 0; pwm_out[2] and pwm_out[3] constant 1 across several wraps; channel 0 unaffected.
REQ-032 The bench SHALL cover: prescale=4, duty0=10, changed to prescale=1 mid-period -> the current period is 500 clks with 50 high; the next period is 200 clks with 20 high.
REQ-033 The bench SHALL cover: rstn pulsed low for 3 clks at cnt=57 -> all outputs 0 immediately (asynchronously), cnt restarts at 0 after release, and pwm_out stays 0 until a duty write plus a wrap.
REQ-034 The bench SHALL cover: with PWM_MULTI_CH_CENTER_ALIGN_EN defined, STEPS=100, prescale=0, duty0=50 -> period_tick every 198 clks, and pwm_out[0] high 99 contiguous clks spanning the wrap.
